sort4_ctrl: RTL

SORT4_CTRL -- requirements
Module: sort4_ctrl

---
 rtl/sort4_ctrl_if.sv | 23 ++
 rtl/sort4_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/sort4_ctrl_if.sv
// Handshake bundle for sort4_ctrl: load side, drain side and status.
// slave is the sorter's view; master is the producer/consumer view.
interface sort4_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic [2:0] swap_cnt;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, swap_cnt
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, swap_cnt
    );
endinterface

// File: rtl/sort4_ctrl.sv
// Four-sample batch sorter: load 4 nibbles, bubble sort in 6 fixed cycles
// with a single shared comparator, then stream the result with backpressure.
module sort4_ctrl #(
    parameter bit DESC = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    sort4_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {S_LOAD, S_SORT, S_OUT} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [3:0]  r_buf [4];
    logic [1:0]  r_cnt;
    logic [1:0]  r_k;
    logic [1:0]  r_pass;
    logic [1:0]  r_idx;
    logic [2:0]  r_swap_cnt;

    logic [1:0]  w_idx_n;
    logic [1:0]  w_idx_lim;
    logic [3:0]  w_a;
    logic [3:0]  w_b;
    logic [2:0]  w_cmp;
    logic        w_swap;
    logic        w_pass_end;
    logic        w_sort_done;
    logic        w_in_fire;
    logic        w_out_fire;

    // The only magnitude comparator; it always looks at the pair (i, i+1).
    assign w_idx_n   = r_idx + 2'd1;
    assign w_a       = r_buf[r_idx];
    assign w_b       = r_buf[w_idx_n];
    assign w_cmp     = {(w_a > w_b), (w_a == w_b), (w_a < w_b)};

    // Equal operands never swap, which keeps the sort stable.
    assign w_swap      = (r_state == S_SORT) && !w_cmp[1] && (DESC ? w_cmp[0] : w_cmp[2]);
    assign w_idx_lim   = 2'd2 - r_pass;
    assign w_pass_end  = (r_idx == w_idx_lim);
    assign w_sort_done = (r_state == S_SORT) && w_pass_end && (r_pass == 2'd2);
    assign w_in_fire   = (r_state == S_LOAD) && bus.in_valid;
    assign w_out_fire  = (r_state == S_OUT) && bus.out_ready;

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_buf[r_k];
    assign bus.out_last  = (r_state == S_OUT) && (r_k == 2'd3);
    assign bus.busy      = (r_state == S_SORT) || (r_state == S_OUT);
    assign bus.swap_cnt  = r_swap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && (r_cnt == 2'd3)) w_next = S_SORT;
            S_SORT:  if (w_sort_done) w_next = S_OUT;
            S_OUT:   if (w_out_fire && (r_k == 2'd3)) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt      <= '0;
            r_k        <= '0;
            r_pass     <= '0;
            r_idx      <= '0;
            r_swap_cnt <= '0;
        end else begin
            if (w_in_fire) begin
                r_buf[r_cnt] <= bus.in_data;
                r_cnt        <= r_cnt + 2'd1;
                // swap_cnt stays readable through OUT and clears only when a new batch starts.
                if (r_cnt == 2'd0) begin
                    r_swap_cnt <= '0;
                end
            end

            if (r_state == S_SORT) begin
                if (w_swap) begin
                    r_buf[r_idx]   <= w_b;
                    r_buf[w_idx_n] <= w_a;
                    r_swap_cnt     <= r_swap_cnt + 3'd1;
                end
                if (w_pass_end) begin
                    r_idx  <= '0;
                    r_pass <= w_sort_done ? 2'd0 : r_pass + 2'd1;
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end

            // k wraps 3 -> 0 on the final transfer, ready for the next batch.
            if (w_out_fire) begin
                r_k <= r_k + 2'd1;
            end
        end
    end

endmodule
